// File: rtl/genie_mem_pkg.sv
// Shared constants and encodings for the engine-to-DRAM port arbiter.
package genie_mem_pkg;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int OWN_W  = 2;

  // Requester indices into the packed request buses.
  localparam logic [OWN_W-1:0] REQ_FC = 2'd0;
  localparam logic [OWN_W-1:0] REQ_CV = 2'd1;
  localparam logic [OWN_W-1:0] REQ_MP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  int   idx;
  logic found;

  // Scan ptr, ptr+1, ... modulo N and keep the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter for the single external memory port shared by the
// FC, CV and MP engines. One burst at a time; grant held until last beat.
// Handshake rule on every channel: a transfer happens in a cycle where
// valid and ready are both high; valid never depends on ready, and the
// read channel has no ready (every mem_rvalid cycle is a beat).
module dram_port_arbiter
  import genie_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  input  logic [N_REQ-1:0]        wr_valid,
  output logic [N_REQ-1:0]        wr_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_we,
  output logic [ADDR_W-1:0]       mem_cmd_addr,
  output logic [LEN_W-1:0]        mem_cmd_len,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_wvalid,
  input  logic                    mem_wready,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    busy,
  output logic [OWN_W-1:0]        owner,
  output logic                    protocol_err,
  output logic [1:0]              dbg_state
);

  arb_state_t       state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick_oh;
  logic [OWN_W-1:0] pick_idx;
  logic [N_REQ-1:0] owner_oh;
  logic             beat;

  rr_picker #(.N(N_REQ), .IW(OWN_W)) u_picker (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  // State, grant and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus command/data steering to and from the owner.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    we_d          = we_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    req_ready     = '0;
    wr_ready      = '0;
    rd_valid      = '0;
    rd_data       = '0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_len   = '0;
    mem_wdata     = '0;
    mem_wvalid    = 1'b0;
    beat          = 1'b0;
    owner_oh      = '0;
    owner_oh[owner_q] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|pick_oh) begin
          owner_d = pick_idx;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = req_we[owner_q];
        mem_cmd_addr  = req_addr[owner_q*ADDR_W +: ADDR_W];
        mem_cmd_len   = req_len[owner_q*LEN_W +: LEN_W];
        if (mem_cmd_ready) begin
          req_ready = owner_oh;
          we_d      = req_we[owner_q];
          len_d     = req_len[owner_q*LEN_W +: LEN_W];
          cnt_d     = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (we_q) begin
          mem_wvalid = wr_valid[owner_q];
          mem_wdata  = wr_data[owner_q*DATA_W +: DATA_W];
          wr_ready   = owner_oh & {N_REQ{mem_wready}};
          beat       = wr_valid[owner_q] && mem_wready;
        end else begin
          rd_valid = owner_oh & {N_REQ{mem_rvalid}};
          rd_data  = mem_rdata;
          beat     = mem_rvalid;
        end
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // Equality compare so len = 255 runs the full 256 beats.
          if (cnt_q == len_q) begin
            state_d = S_IDLE;
            ptr_d   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read beats outside a read burst are dropped and flagged.
    if (mem_rvalid && (state_q != S_DATA || we_q)) err_d = 1'b1;
    if (state_q == S_DATA && |(wr_valid & ~owner_oh)) err_d = 1'b1;
  end

  assign busy         = (state_q != S_IDLE);
  assign owner        = owner_q;
  assign protocol_err = err_q;
  assign dbg_state    = state_q;

endmodule
